// File: rtl/sipo_deser_pkg.sv
// Shared constants and helpers for the serial-to-parallel deserializer.
// Bit-order mode values and the counter width function live here.
package sipo_deser_pkg;

    localparam bit MODE_MSB_FIRST = 1'b1;
    localparam bit MODE_LSB_FIRST = 1'b0;

    // Width needed to hold 0..value-1; at least 1 for any legal word length.
    function automatic int sipo_clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sipo_shreg.sv
// WIDTH-bit serial shift register with enable, selectable direction,
// synchronous clear and asynchronous active-low clear.
module sipo_shreg
    import sipo_deser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = MODE_MSB_FIRST
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             flush,
    input  logic             en,
    input  logic             in,
    output logic [WIDTH-1:0] shreg,
    output logic [WIDTH-1:0] shreg_nxt
);

    // The post-shift value is exported so the wrapper can capture a word
    // at the same edge that samples its final bit.
    always_comb begin
        shreg_nxt = shreg;
        if (MSB_FIRST) begin
            shreg_nxt = {shreg[WIDTH-2:0], in};
        end else begin
            shreg_nxt = {in, shreg[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            shreg <= '0;
        end else if (flush) begin
            shreg <= '0;
        end else if (en) begin
            shreg <= shreg_nxt;
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// Serial-to-parallel deserializer: frames WIDTH-bit words from a qualified
// bit stream and offers them through a valid/ready holding register.
module sipo_deser
    import sipo_deser_pkg::*;
#(
    parameter int  WIDTH     = 8,
    parameter bit  MSB_FIRST = MODE_MSB_FIRST,
    localparam int CW        = sipo_clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             flush,
    input  logic             in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] shift_out,
    output logic [CW-1:0]    bit_cnt,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun
);

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shreg_nxt;
    logic             word_done;
    logic             hold_free;

    sipo_shreg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk       (clk),
        .clr       (clr),
        .flush     (flush),
        .en        (in_valid),
        .in        (in),
        .shreg     (shift_out),
        .shreg_nxt (shreg_nxt)
    );

    assign word_done = in_valid && (bit_cnt == LAST_BIT);
    // A consumer draining the register this cycle frees it for the new word.
    assign hold_free = !out_valid || out_ready;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            bit_cnt   <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (flush) begin
            bit_cnt   <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (in_valid) begin
                bit_cnt <= word_done ? '0 : bit_cnt + CW'(1);
            end
            if (word_done && hold_free) begin
                data_out  <= shreg_nxt;
                out_valid <= 1'b1;
            end else begin
                if (word_done) begin
                    overrun <= 1'b1;
                end
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser: an MSB-first and an LSB-first instance
// share stimulus; completed words are scoreboarded and checked on transfer.
module tb_sipo_deser;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       flush = 1'b0;
    logic       in = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;

    logic [7:0] m_shift, l_shift, m_data, l_data;
    logic [2:0] m_cnt, l_cnt;
    logic       m_valid, l_valid, m_ovr, l_ovr;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] q_m[$];
    logic [7:0] q_l[$];

    always #5 clk = ~clk;

    sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .clr(clr), .flush(flush), .in(in), .in_valid(in_valid),
        .shift_out(m_shift), .bit_cnt(m_cnt), .data_out(m_data),
        .out_valid(m_valid), .out_ready(out_ready), .overrun(m_ovr)
    );

    sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .clr(clr), .flush(flush), .in(in), .in_valid(in_valid),
        .shift_out(l_shift), .bit_cnt(l_cnt), .data_out(l_data),
        .out_valid(l_valid), .out_ready(out_ready), .overrun(l_ovr)
    );

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    // Transfers are observed on the falling edge, before the edge that commits them.
    always @(negedge clk) begin
        if (clr && !flush && m_valid && out_ready) begin
            n_checks++;
            if (q_m.size() == 0) $display("FAIL sb_msb: unexpected word %h, none expected", m_data);
            else begin
                logic [7:0] e;
                e = q_m.pop_front();
                if (m_data !== e) $display("FAIL sb_msb: got %h want %h", m_data, e);
                else n_pass++;
            end
        end
        if (clr && !flush && l_valid && out_ready) begin
            n_checks++;
            if (q_l.size() == 0) $display("FAIL sb_lsb: unexpected word %h, none expected", l_data);
            else begin
                logic [7:0] e;
                e = q_l.pop_front();
                if (l_data !== e) $display("FAIL sb_lsb: got %h want %h", l_data, e);
                else n_pass++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends the top nbits of w, first bit = w[7]; pushes expectations if the word completes and is kept.
    task automatic send_bits(input logic [7:0] w, input int nbits, input bit push);
        for (int i = 7; i > 7 - nbits; i--) begin
            in = w[i];
            in_valid = 1'b1;
            if (i == 0 && push) begin
                q_m.push_back(w);
                q_l.push_back(rev8(w));
            end
            step();
        end
        in_valid = 1'b0;
        in = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b0;
        #3;
        n_checks++;
        if ({m_shift, m_cnt, m_data, m_valid, m_ovr} !== 27'd0)
            $display("FAIL reset_msb: got %h want 0", {m_shift, m_cnt, m_data, m_valid, m_ovr});
        else n_pass++;
        n_checks++;
        if ({l_shift, l_cnt, l_data, l_valid, l_ovr} !== 27'd0)
            $display("FAIL reset_lsb: got %h want 0", {l_shift, l_cnt, l_data, l_valid, l_ovr});
        else n_pass++;
        step();
        step();
        clr = 1'b1;
        step();
    endtask

    task automatic test_bit_order();
        out_ready = 1'b1;
        send_bits(8'h1F, 8, 1'b1);
        n_checks++;
        if ({m_valid, m_data} !== {1'b1, 8'h1F}) $display("FAIL order_msb: got %b/%h want 1/1f", m_valid, m_data);
        else n_pass++;
        n_checks++;
        if ({l_valid, l_data} !== {1'b1, 8'hF8}) $display("FAIL order_lsb: got %b/%h want 1/f8", l_valid, l_data);
        else n_pass++;
        n_checks++;
        if (m_cnt !== 3'd0) $display("FAIL order_cnt_wrap: got %0d want 0", m_cnt);
        else n_pass++;
        step();
        n_checks++;
        if ({m_valid, l_valid} !== 2'b00) $display("FAIL order_pulse: got %b want 00", {m_valid, l_valid});
        else n_pass++;
        n_checks++;
        if (m_shift !== 8'h1F) $display("FAIL order_shift_out: got %h want 1f", m_shift);
        else n_pass++;
    endtask

    task automatic test_gapped();
        logic [7:0] w;
        int errs;
        w = 8'h1F;
        errs = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in = w[7-i];
            in_valid = 1'b1;
            if (i == 7) begin
                q_m.push_back(w);
                q_l.push_back(rev8(w));
            end
            step();
            if (i < 7) begin
                if (m_valid !== 1'b0 || m_cnt !== 3'(i + 1)) errs++;
                in_valid = 1'b0;
                in = ~in;
                step();
                if (m_valid !== 1'b0 || m_cnt !== 3'(i + 1)) errs++;
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (errs != 0) $display("FAIL gap_hold: got %0d bad cycles want 0", errs);
        else n_pass++;
        n_checks++;
        if ({m_valid, m_data} !== {1'b1, 8'h1F}) $display("FAIL gap_word: got %b/%h want 1/1f", m_valid, m_data);
        else n_pass++;
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        send_bits(8'hC3, 8, 1'b1);
        send_bits(8'h96, 8, 1'b1);
        n_checks++;
        if ({m_valid, m_data, l_data} !== {1'b1, 8'h96, 8'h69})
            $display("FAIL b2b_word: got %b/%h/%h want 1/96/69", m_valid, m_data, l_data);
        else n_pass++;
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_bits(8'h3C, 8, 1'b1);
        send_bits(8'h81, 8, 1'b0);
        n_checks++;
        if ({m_valid, m_data, m_ovr, l_ovr} !== {1'b1, 8'h3C, 2'b11})
            $display("FAIL bp_hold: got %b/%h/%b want 1/3c/11", m_valid, m_data, {m_ovr, l_ovr});
        else n_pass++;
        n_checks++;
        if (m_cnt !== 3'd0) $display("FAIL bp_framing: got %0d want 0", m_cnt);
        else n_pass++;
        step();
        n_checks++;
        if (m_data !== 8'h3C) $display("FAIL bp_stable: got %h want 3c", m_data);
        else n_pass++;
        out_ready = 1'b1;
        step();
        n_checks++;
        if ({m_valid, m_ovr} !== 2'b01) $display("FAIL bp_drain: got %b want 01", {m_valid, m_ovr});
        else n_pass++;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        send_bits(8'h11, 8, 1'b0);
        send_bits(8'hE0, 3, 1'b0);
        n_checks++;
        if ({m_valid, m_ovr, m_cnt} !== {2'b11, 3'd3}) $display("FAIL flush_pre: got %b want 11011", {m_valid, m_ovr, m_cnt});
        else n_pass++;
        flush = 1'b1;
        in = 1'b1;
        in_valid = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        in = 1'b0;
        n_checks++;
        if ({m_shift, m_cnt, m_data, m_valid, m_ovr} !== 27'd0)
            $display("FAIL flush_clear: got %h want 0", {m_shift, m_cnt, m_data, m_valid, m_ovr});
        else n_pass++;
        n_checks++;
        if ({l_shift, l_cnt, l_data, l_valid, l_ovr} !== 27'd0)
            $display("FAIL flush_clear_lsb: got %h want 0", {l_shift, l_cnt, l_data, l_valid, l_ovr});
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        out_ready = 1'b0;
        send_bits(8'h33, 8, 1'b1);
        send_bits(8'h5A, 7, 1'b0);
        out_ready = 1'b1;
        in = 1'b0;
        in_valid = 1'b1;
        q_m.push_back(8'h5A);
        q_l.push_back(rev8(8'h5A));
        step();
        in_valid = 1'b0;
        n_checks++;
        if ({m_valid, m_data, m_ovr} !== {1'b1, 8'h5A, 1'b0})
            $display("FAIL simul: got %b/%h/%b want 1/5a/0", m_valid, m_data, m_ovr);
        else n_pass++;
        step();
        n_checks++;
        if (m_valid !== 1'b0) $display("FAIL simul_drain: got %b want 0", m_valid);
        else n_pass++;
    endtask

    task automatic test_reset_midword();
        out_ready = 1'b1;
        send_bits(8'hF0, 4, 1'b0);
        n_checks++;
        if (m_cnt !== 3'd4) $display("FAIL mid_cnt: got %0d want 4", m_cnt);
        else n_pass++;
        #2;
        clr = 1'b0;
        #1;
        n_checks++;
        if ({m_shift, m_cnt, m_data, m_valid, m_ovr} !== 27'd0)
            $display("FAIL mid_async: got %h want 0", {m_shift, m_cnt, m_data, m_valid, m_ovr});
        else n_pass++;
        step();
        clr = 1'b1;
        step();
        send_bits(8'hA6, 8, 1'b1);
        n_checks++;
        if ({m_valid, m_data} !== {1'b1, 8'hA6}) $display("FAIL mid_word: got %b/%h want 1/a6", m_valid, m_data);
        else n_pass++;
        step();
    endtask

    initial begin
        test_reset();
        test_bit_order();
        test_gapped();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_simultaneous();
        test_reset_midword();
        step();
        n_checks++;
        if (q_m.size() + q_l.size() != 0)
            $display("FAIL sb_drain: got %0d pending words want 0", q_m.size() + q_l.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
